lsu_bus_ctrl: RTL and testbench

- Parametrised successor to the pipeline load/store unit.
- Replaces the zero-latency memory access with a valid/ready request/response bus, so memory may take any number of cycles.
- Adds XLEN generalisation (32/64), store-lane alignment, misalignment/illegal-op faulting and a back-pressured MEM->WB handshake.
- Sits between EX and WB; drives the data-memory port.

---
 rtl/lsu_bus_ctrl_pkg.sv | 51 +++++
 rtl/lsu_lane_align.sv | 85 ++++++++
 rtl/lsu_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// rtl/lsu_bus_ctrl_pkg.sv - shared op encodings, FSM states and access-size helpers for the LSU
package lsu_bus_ctrl_pkg;

   // ls_ctl op codes
   localparam logic [3:0] LS_NONE = 4'b0000;
   localparam logic [3:0] LS_SB   = 4'b0001;
   localparam logic [3:0] LS_SH   = 4'b0010;
   localparam logic [3:0] LS_SW   = 4'b0100;
   localparam logic [3:0] LS_SD   = 4'b0101;
   localparam logic [3:0] LS_LB   = 4'b1001;
   localparam logic [3:0] LS_LH   = 4'b1010;
   localparam logic [3:0] LS_LW   = 4'b1011;
   localparam logic [3:0] LS_LD   = 4'b1100;
   localparam logic [3:0] LS_LBU  = 4'b1101;
   localparam logic [3:0] LS_LHU  = 4'b1110;
   localparam logic [3:0] LS_LWU  = 4'b1111;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } acc_size_e;

   // Access size of a memory op; byte for anything that is not a sized access.
   function automatic acc_size_e ls_size(input logic [3:0] ctl);
      case (ctl)
         LS_SH, LS_LH, LS_LHU:  ls_size = SZ_H;
         LS_SW, LS_LW, LS_LWU:  ls_size = SZ_W;
         LS_SD, LS_LD:          ls_size = SZ_D;
         default:               ls_size = SZ_B;
      endcase
   endfunction

   // True for every defined memory op (excludes LS_NONE and the holes in the map).
   function automatic logic ls_known(input logic [3:0] ctl);
      case (ctl)
         LS_SB, LS_SH, LS_SW, LS_SD,
         LS_LB, LS_LH, LS_LW, LS_LD,
         LS_LBU, LS_LHU, LS_LWU: ls_known = 1'b1;
         default:                ls_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, load extension and fault detection for one access
module lsu_lane_align
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int   XLEN   = 64,
   localparam int  STRB_W = XLEN / 8,
   localparam int  OFF_W  = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]  offset_i,
   input  logic [3:0]        ls_ctl_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic [XLEN-1:0]   rdata_i,
   output logic [XLEN-1:0]   wdata_o,
   output logic [STRB_W-1:0] wstrb_o,
   output logic [XLEN-1:0]   load_o,
   output logic              fault_o
);

   localparam int SH_W = $clog2(XLEN);

   acc_size_e       size;
   logic [SH_W-1:0] sh_amt;
   logic [XLEN-1:0] rshift;
   logic [2:0]      off3;
   logic [2:0]      size_mask;
   logic            is_store;
   logic            xlen_illegal;

   assign size     = ls_size(ls_ctl_i);
   assign sh_amt   = {offset_i, 3'b000};
   assign rshift   = rdata_i >> sh_amt;
   assign off3     = 3'(offset_i);
   assign is_store = !ls_ctl_i[3] && ls_known(ls_ctl_i);

   // Doubleword ops and lwu have no meaning on a 32-bit datapath.
   assign xlen_illegal = (XLEN == 32) &&
                         ((ls_ctl_i == LS_LD) || (ls_ctl_i == LS_LWU) || (ls_ctl_i == LS_SD));

   // Offset bits that must be zero for a naturally aligned access of this size.
   always_comb begin
      size_mask = 3'b000;
      case (size)
         SZ_B:    size_mask = 3'b000;
         SZ_H:    size_mask = 3'b001;
         SZ_W:    size_mask = 3'b011;
         SZ_D:    size_mask = 3'b111;
         default: size_mask = 3'b111;
      endcase
   end

   assign fault_o = (ls_ctl_i != LS_NONE) &&
                    (!ls_known(ls_ctl_i) || xlen_illegal || (|(off3 & size_mask)));

   assign wdata_o = is_store ? (store_data_i << sh_amt) : '0;

   // Byte enables follow the store size and lane; reads never enable bytes.
   always_comb begin
      wstrb_o = '0;
      if (is_store) begin
         case (size)
            SZ_B:    wstrb_o = STRB_W'(1)     << offset_i;
            SZ_H:    wstrb_o = STRB_W'(2'b11) << offset_i;
            SZ_W:    wstrb_o = STRB_W'(4'hF)  << offset_i;
            SZ_D:    wstrb_o = '1;
            default: wstrb_o = '0;
         endcase
      end
   end

   // Pick the addressed lane out of the read word and extend it to XLEN.
   always_comb begin
      load_o = '0;
      case (ls_ctl_i)
         LS_LB:   load_o = XLEN'($signed(rshift[7:0]));
         LS_LBU:  load_o = XLEN'(rshift[7:0]);
         LS_LH:   load_o = XLEN'($signed(rshift[15:0]));
         LS_LHU:  load_o = XLEN'(rshift[15:0]);
         LS_LW:   load_o = XLEN'($signed(rshift[31:0]));
         LS_LWU:  load_o = XLEN'(rshift[31:0]);
         LS_LD:   load_o = rshift;
         default: load_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - load/store unit between EX and WB with a valid/ready data-memory bus
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int  XLEN   = 64,
   localparam int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ls_ready,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [XLEN-1:0]   store_data,
   input  logic [3:0]        ls_ctl,
   output logic              ls_valid,
   input  logic              wb_ready,
   output logic [XLEN-1:0]   ls_data_o,
   output logic              ls_fault,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [STRB_W-1:0] mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata
);

   localparam int              OFF_W      = $clog2(STRB_W);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(STRB_W - 1));

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q,  addr_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic [3:0]      ctl_q,   ctl_d;
   logic [XLEN-1:0] res_q,   res_d;
   logic            fault_q, fault_d;

   logic              in_idle;
   logic              in_req;
   logic [XLEN-1:0]   op_addr;
   logic [XLEN-1:0]   op_sdata;
   logic [3:0]        op_ctl;
   logic [XLEN-1:0]   la_wdata;
   logic [STRB_W-1:0] la_wstrb;
   logic [XLEN-1:0]   la_load;
   logic              la_fault;

   assign in_idle = (state_q == ST_IDLE);
   assign in_req  = (state_q == ST_REQ);

   // In IDLE the aligner sees the live EX op so a fault can be decided at accept;
   // afterwards it works from the latched copy so EX changes cannot leak in.
   assign op_addr  = in_idle ? alu_res    : addr_q;
   assign op_sdata = in_idle ? store_data : sdata_q;
   assign op_ctl   = in_idle ? ls_ctl     : ctl_q;

   lsu_lane_align #(
      .XLEN (XLEN)
   ) u_lane_align (
      .offset_i     (op_addr[OFF_W-1:0]),
      .ls_ctl_i     (op_ctl),
      .store_data_i (op_sdata),
      .rdata_i      (mem_rsp_rdata),
      .wdata_o      (la_wdata),
      .wstrb_o      (la_wstrb),
      .load_o       (la_load),
      .fault_o      (la_fault)
   );

   // Next-state logic: accept in IDLE, bus request, wait for response, hold for WB.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      ctl_d   = ctl_q;
      res_d   = res_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               addr_d  = alu_res;
               sdata_d = store_data;
               ctl_d   = ls_ctl;
               if (ls_ctl == LS_NONE) begin
                  res_d   = alu_res;
                  fault_d = 1'b0;
                  state_d = ST_HOLD;
               end else if (la_fault) begin
                  res_d   = '0;
                  fault_d = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  fault_d = 1'b0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            if (mem_rsp_valid) begin
               res_d   = ctl_q[3] ? la_load : '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (wb_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and op registers; reset abandons any bus transaction immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         ctl_q   <= LS_NONE;
         res_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         ctl_q   <= ctl_d;
         res_q   <= res_d;
         fault_q <= fault_d;
      end
   end

   assign ls_ready  = in_idle;
   assign ls_valid  = (state_q == ST_HOLD);
   assign ls_data_o = res_q;
   assign ls_fault  = fault_q;

   // Only REQ reaches this state with a legal memory op, so bit 3 alone tells load from store.
   assign mem_req_valid = in_req;
   assign mem_req_we    = in_req && !ctl_q[3];
   assign mem_req_addr  = in_req ? (addr_q & ALIGN_MASK) : '0;
   assign mem_req_wdata = in_req ? la_wdata : '0;
   assign mem_req_wstrb = in_req ? la_wstrb : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - directed self-checking bench for lsu_bus_ctrl at XLEN 64 and 32
module tb_lsu_bus_ctrl;

   logic clk;
   logic rst;

   int n_checks;
   int n_errors;

   // XLEN = 64 instance
   logic        a_ex_valid, a_ls_ready, a_ls_valid, a_wb_ready, a_ls_fault;
   logic [63:0] a_alu_res, a_store_data, a_ls_data;
   logic [3:0]  a_ls_ctl;
   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
   logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [7:0]  a_req_wstrb;

   // XLEN = 32 instance
   logic        b_ex_valid, b_ls_ready, b_ls_valid, b_wb_ready, b_ls_fault;
   logic [31:0] b_alu_res, b_store_data, b_ls_data;
   logic [3:0]  b_ls_ctl;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_wstrb;

   lsu_bus_ctrl #(.XLEN(64)) u_dut64 (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (a_ex_valid),
      .ls_ready      (a_ls_ready),
      .alu_res       (a_alu_res),
      .store_data    (a_store_data),
      .ls_ctl        (a_ls_ctl),
      .ls_valid      (a_ls_valid),
      .wb_ready      (a_wb_ready),
      .ls_data_o     (a_ls_data),
      .ls_fault      (a_ls_fault),
      .mem_req_valid (a_req_valid),
      .mem_req_ready (a_req_ready),
      .mem_req_we    (a_req_we),
      .mem_req_addr  (a_req_addr),
      .mem_req_wdata (a_req_wdata),
      .mem_req_wstrb (a_req_wstrb),
      .mem_rsp_valid (a_rsp_valid),
      .mem_rsp_rdata (a_rsp_rdata)
   );

   lsu_bus_ctrl #(.XLEN(32)) u_dut32 (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (b_ex_valid),
      .ls_ready      (b_ls_ready),
      .alu_res       (b_alu_res),
      .store_data    (b_store_data),
      .ls_ctl        (b_ls_ctl),
      .ls_valid      (b_ls_valid),
      .wb_ready      (b_wb_ready),
      .ls_data_o     (b_ls_data),
      .ls_fault      (b_ls_fault),
      .mem_req_valid (b_req_valid),
      .mem_req_ready (b_req_ready),
      .mem_req_we    (b_req_we),
      .mem_req_addr  (b_req_addr),
      .mem_req_wdata (b_req_wdata),
      .mem_req_wstrb (b_req_wstrb),
      .mem_rsp_valid (b_rsp_valid),
      .mem_rsp_rdata (b_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One op on the 64-bit unit: a bench-side memory holds ready low for rdy_wait
   // request cycles, and WB holds wb_ready low for wb_wait HOLD cycles.
   task automatic op64(input string tag, input logic [3:0] ctl, input logic [63:0] alu,
                       input logic [63:0] sd, input logic [63:0] rdata,
                       input int rdy_wait, input int wb_wait,
                       input logic [63:0] e_addr, input logic e_we, input logic [63:0] e_wdata,
                       input logic [7:0] e_wstrb, input logic [63:0] e_data, input logic e_fault,
                       input int e_lat);
      int cyc, reqc, hs, e_reqc;
      bit got, bad_pl, bad_busy, bad_hold;
      cyc = 0; reqc = 0; hs = 0; got = 0; bad_pl = 0; bad_busy = 0; bad_hold = 0;
      e_reqc = (e_fault || ctl == 4'b0000) ? 0 : rdy_wait + 1;
      a_ex_valid   = 1'b1;
      a_ls_ctl     = ctl;
      a_alu_res    = alu;
      a_store_data = sd;
      a_rsp_rdata  = rdata;
      a_req_ready  = 1'b0;
      a_rsp_valid  = 1'b0;
      a_wb_ready   = (wb_wait == 0);
      tick();
      // Junk on the EX side while busy must have no effect.
      a_ls_ctl     = 4'b1100;
      a_alu_res    = 64'hFFFF_FFFF_FFFF_FFFF;
      a_store_data = 64'h5A5A_5A5A_5A5A_5A5A;
      while (!got && cyc < 40) begin
         cyc++;
         if (a_ls_ready) bad_busy = 1;
         if (a_req_valid) begin
            reqc++;
            if (a_req_addr !== e_addr || a_req_we !== e_we ||
                a_req_wdata !== e_wdata || a_req_wstrb !== e_wstrb) bad_pl = 1;
            a_req_ready = (reqc > rdy_wait);
            if (a_req_ready) begin
               hs++;
               a_rsp_valid = 1'b1;
            end
         end else begin
            a_req_ready = 1'b0;
         end
         if (a_ls_valid) got = 1;
         else tick();
      end
      a_rsp_valid = 1'b0;
      check_eq({tag, "_valid_seen"}, 64'(got), 64'd1);
      check_eq({tag, "_latency"},    64'(cyc), 64'(e_lat));
      check_eq({tag, "_data"},       a_ls_data, e_data);
      check_eq({tag, "_fault"},      64'(a_ls_fault), 64'(e_fault));
      check_eq({tag, "_req_cycles"}, 64'(reqc), 64'(e_reqc));
      check_eq({tag, "_handshakes"}, 64'(hs), (e_reqc != 0) ? 64'd1 : 64'd0);
      check_eq({tag, "_payload_bad"}, 64'(bad_pl), 64'd0);
      check_eq({tag, "_busy_ready"}, 64'(bad_busy), 64'd0);
      for (int i = 1; i < wb_wait; i++) begin
         tick();
         if (!a_ls_valid || a_ls_data !== e_data || a_ls_ready || a_req_valid) bad_hold = 1;
      end
      if (wb_wait > 0) check_eq({tag, "_hold_stable_bad"}, 64'(bad_hold), 64'd0);
      a_wb_ready = 1'b1;
      tick();
      a_ex_valid = 1'b0;
      check_eq({tag, "_rel_valid"}, 64'(a_ls_valid), 64'd0);
      check_eq({tag, "_rel_ready"}, 64'(a_ls_ready), 64'd1);
      tick();
      check_eq({tag, "_bubble_idle"}, 64'(a_ls_ready && !a_req_valid), 64'd1);
   endtask

   // One op on the 32-bit unit with a memory that is always ready and responding.
   task automatic op32(input string tag, input logic [3:0] ctl, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] e_addr,
                       input logic [31:0] e_data, input logic e_fault, input int e_lat);
      int cyc;
      bit got, saw_req;
      logic [31:0] seen_addr;
      cyc = 0; got = 0; saw_req = 0; seen_addr = '0;
      b_ex_valid  = 1'b1;
      b_ls_ctl    = ctl;
      b_alu_res   = alu;
      b_rsp_rdata = rdata;
      tick();
      b_ex_valid = 1'b0;
      while (!got && cyc < 40) begin
         cyc++;
         if (b_req_valid) begin
            saw_req   = 1;
            seen_addr = b_req_addr;
         end
         if (b_ls_valid) got = 1;
         else tick();
      end
      check_eq({tag, "_latency"}, 64'(cyc), 64'(e_lat));
      check_eq({tag, "_data"},    64'(b_ls_data), 64'(e_data));
      check_eq({tag, "_fault"},   64'(b_ls_fault), 64'(e_fault));
      check_eq({tag, "_req_seen"}, 64'(saw_req), 64'(!e_fault));
      if (!e_fault) check_eq({tag, "_addr"}, 64'(seen_addr), 64'(e_addr));
      tick();
      check_eq({tag, "_rel_ready"}, 64'(b_ls_ready), 64'd1);
   endtask

   initial begin
      bit bad_spur;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      a_ex_valid = 0; a_ls_ctl = 0; a_alu_res = 0; a_store_data = 0; a_wb_ready = 1;
      a_req_ready = 0; a_rsp_valid = 0; a_rsp_rdata = 0;
      b_ex_valid = 0; b_ls_ctl = 0; b_alu_res = 0; b_store_data = 0; b_wb_ready = 1;
      b_req_ready = 1; b_rsp_valid = 1; b_rsp_rdata = 0;
      tick();
      tick();
      check_eq("rst_ls_ready",  64'(a_ls_ready), 64'd1);
      check_eq("rst_ls_valid",  64'(a_ls_valid), 64'd0);
      check_eq("rst_req_valid", 64'(a_req_valid), 64'd0);
      check_eq("rst_ls_data",   a_ls_data, 64'd0);
      rst = 1'b1;
      tick();

      //    tag       ctl      alu                     store_data               rdata                    rw wb addr                    we    wdata                    wstrb  data                     flt lat
      op64("lb",    4'b1001, 64'h0000_0000_8000_0003, 64'h0,                   64'h1122_3344_8566_7788, 0, 0, 64'h0000_0000_8000_0000, 1'b0, 64'h0,                   8'h00, 64'hFFFF_FFFF_FFFF_FF85, 1'b0, 3);
      op64("sh",    4'b0010, 64'h1006,                64'hABCD,                64'h0,                   4, 0, 64'h1000,                1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0,                   1'b0, 7);
      op64("lw_mis",4'b1011, 64'h1002,                64'h0,                   64'h0,                   0, 0, 64'h0,                   1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1, 1);
      op64("none",  4'b0000, 64'h1234,                64'h0,                   64'h0,                   0, 5, 64'h0,                   1'b0, 64'h0,                   8'h00, 64'h1234,                1'b0, 1);
      op64("sd",    4'b0101, 64'h2008,                64'h0123_4567_89AB_CDEF, 64'h0,                   0, 0, 64'h2008,                1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                   1'b0, 3);
      op64("sb",    4'b0001, 64'h5,                   64'h1FF,                 64'h0,                   0, 0, 64'h0,                   1'b1, 64'h0001_FF00_0000_0000, 8'h20, 64'h0,                   1'b0, 3);
      op64("lwu",   4'b1111, 64'h104,                 64'h0,                   64'hF00D_BEEF_1234_5678, 1, 0, 64'h100,                 1'b0, 64'h0,                   8'h00, 64'h0000_0000_F00D_BEEF, 1'b0, 4);
      op64("lw",    4'b1011, 64'h104,                 64'h0,                   64'hF00D_BEEF_1234_5678, 0, 0, 64'h100,                 1'b0, 64'h0,                   8'h00, 64'hFFFF_FFFF_F00D_BEEF, 1'b0, 3);
      op64("undef", 4'b0011, 64'h0,                   64'h0,                   64'h0,                   0, 0, 64'h0,                   1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1, 1);
      op64("sd_mis",4'b0101, 64'h2004,                64'h55,                  64'h0,                   0, 0, 64'h0,                   1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1, 1);
      op64("ld",    4'b1100, 64'h3000,                64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 0, 0, 64'h3000,                1'b0, 64'h0,                   8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3);

      op32("rv32_ld",  4'b1100, 32'h0, 32'h0,         32'h0, 32'h0,         1'b1, 1);
      op32("rv32_lhu", 4'b1110, 32'h2, 32'h8001_0000, 32'h0, 32'h0000_8001, 1'b0, 3);
      op32("rv32_sd",  4'b0101, 32'h0, 32'h0,         32'h0, 32'h0,         1'b1, 1);
      op32("rv32_lw",  4'b1011, 32'h4, 32'h8000_0000, 32'h4, 32'h8000_0000, 1'b0, 3);

      // Reset while waiting for a read response, then a stray response afterwards.
      a_ex_valid  = 1'b1;
      a_ls_ctl    = 4'b1001;
      a_alu_res   = 64'h8000_0003;
      a_rsp_rdata = 64'h1122_3344_8566_7788;
      tick();
      a_ex_valid  = 1'b0;
      check_eq("rr_req_valid", 64'(a_req_valid), 64'd1);
      a_req_ready = 1'b1;
      tick();
      a_req_ready = 1'b0;
      check_eq("rr_in_rsp", 64'(a_req_valid || a_ls_valid || a_ls_ready), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rr_ls_ready",  64'(a_ls_ready), 64'd1);
      check_eq("rr_req_valid_drop", 64'(a_req_valid), 64'd0);
      check_eq("rr_ls_valid",  64'(a_ls_valid), 64'd0);
      check_eq("rr_ls_data",   a_ls_data, 64'd0);
      check_eq("rr_req_addr",  a_req_addr, 64'd0);
      tick();
      rst = 1'b1;
      a_rsp_valid = 1'b1;
      bad_spur = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (a_ls_valid || !a_ls_ready || a_req_valid || a_ls_data !== 64'd0) bad_spur = 1;
      end
      a_rsp_valid = 1'b0;
      check_eq("rr_spurious_rsp_bad", 64'(bad_spur), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
